// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, grant owner, streak sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // Counter must be able to hold STARVE_LIMIT itself, since it saturates there.
  function automatic int streak_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/data request ports, responses, hazard wait flags and memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic              dreq_write;
  logic [STRB_W-1:0] dreq_strobe;
  logic [DATA_W-1:0] dreq_wdata;

  logic              iresp_ok;
  logic              dresp_ok;
  logic [DATA_W-1:0] resp_data;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [STRB_W-1:0] mem_strobe;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              i_wait;
  logic              d_wait;

  modport slave (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    output iresp_ok, dresp_ok, resp_data,
    output mem_valid, mem_addr, mem_write, mem_strobe, mem_wdata,
    input  mem_ready, mem_rdata,
    output i_wait, d_wait
  );

  modport master (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    input  iresp_ok, dresp_ok, resp_data,
    input  mem_valid, mem_addr, mem_write, mem_strobe, mem_wdata,
    output mem_ready, mem_rdata,
    input  i_wait, d_wait
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant picker: D wins ties unless it has already won STARVE_LIMIT times in a row.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = streak_width(STARVE_LIMIT)
) (
  input  logic                ireq_valid,
  input  logic                dreq_valid,
  input  logic [STREAK_W-1:0] d_streak,
  output logic                grant_valid,
  output arb_owner_t          owner
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  always_comb begin
    grant_valid = ireq_valid | dreq_valid;
    owner       = OWN_I;
    if (dreq_valid && (!ireq_valid || (d_streak < LIMIT))) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and data access; grant is held until mem_ready,
// and the response is routed straight back to the owner in the completion cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = streak_width(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] wdata;
  } arb_req_t;

  arb_state_t          state, state_next;
  logic [STREAK_W-1:0] d_streak, d_streak_next;
  arb_req_t            req_q, req_next;
  logic                grant_valid;
  arb_owner_t          grant_owner;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + STREAK_W'(1);
  endfunction

  mem_port_arbiter_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STREAK_W     (STREAK_W)
  ) u_pick (
    .ireq_valid  (bus.ireq_valid),
    .dreq_valid  (bus.dreq_valid),
    .d_streak    (d_streak),
    .grant_valid (grant_valid),
    .owner       (grant_owner)
  );

  always_comb begin
    state_next    = state;
    d_streak_next = d_streak;
    req_next      = req_q;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          if (grant_owner == OWN_D) begin
            state_next      = BUSY_D;
            req_next.addr   = bus.dreq_addr;
            req_next.write  = bus.dreq_write;
            req_next.strobe = bus.dreq_strobe;
            req_next.wdata  = bus.dreq_wdata;
            // The streak only counts wins that actually made fetch wait.
            d_streak_next   = bus.ireq_valid ? sat_inc(d_streak) : '0;
          end else begin
            state_next      = BUSY_I;
            req_next.addr   = bus.ireq_addr;
            req_next.write  = 1'b0;
            req_next.strobe = '0;
            req_next.wdata  = '0;
            d_streak_next   = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      d_streak <= '0;
      req_q    <= '0;
    end else begin
      state    <= state_next;
      d_streak <= d_streak_next;
      req_q    <= req_next;
    end
  end

  // mem_valid decodes the state register, so an async reset drops it without waiting for an edge.
  always_comb begin
    bus.mem_valid  = (state != IDLE);
    bus.mem_addr   = req_q.addr;
    bus.mem_write  = req_q.write;
    bus.mem_strobe = req_q.strobe;
    bus.mem_wdata  = req_q.wdata;

    bus.iresp_ok   = (state == BUSY_I) && bus.mem_ready;
    bus.dresp_ok   = (state == BUSY_D) && bus.mem_ready;
    bus.resp_data  = (bus.iresp_ok || bus.dresp_ok) ? bus.mem_rdata : '0;

    bus.i_wait     = bus.ireq_valid & ~bus.iresp_ok;
    bus.d_wait     = bus.dreq_valid & ~bus.dresp_ok;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses, a monitor pops on every ok.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Drive mem_ready for the current cycle and register the response the owner must see.
  task automatic complete(input logic is_d, input logic [31:0] rdata, input logic [31:0] addr);
    exp_t e;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    e.is_d = is_d;
    e.data = rdata;
    e.addr = addr;
    sb.push_back(e);
    smp();
    chk("ok_pulse", 64'(bus.iresp_ok | bus.dresp_ok), 64'd1);
  endtask

  always @(negedge clk) begin
    if (bus.iresp_ok || bus.dresp_ok) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ok actual iresp_ok=%0b dresp_ok=%0b required none (t=%0t)",
                 bus.iresp_ok, bus.dresp_ok, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_onehot", 64'(bus.iresp_ok & bus.dresp_ok), 64'd0);
        chk("resp_owner_d", 64'(bus.dresp_ok), 64'(e.is_d));
        chk("resp_data", 64'(bus.resp_data), 64'(e.data));
        chk("resp_addr", 64'(bus.mem_addr), 64'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = '0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_write  = 1'b0;
    bus.dreq_strobe = '0;
    bus.dreq_wdata  = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = '0;

    // Reset state
    smp();
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_strobe", 64'(bus.mem_strobe), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_oks", 64'({bus.iresp_ok, bus.dresp_ok}), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    chk("rst_streak", 64'(dut.d_streak), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;

    // Lone fetch, memory answers three cycles after mem_valid rises
    cyc();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 32'h100;
    smp();
    chk("fetch_c0_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("fetch_c0_i_wait", 64'(bus.i_wait), 64'd1);
    cyc();
    smp();
    chk("fetch_c1_mem_valid", 64'(bus.mem_valid), 64'd1);
    chk("fetch_c1_mem_addr", 64'(bus.mem_addr), 64'h100);
    chk("fetch_c1_mem_write", 64'(bus.mem_write), 64'd0);
    chk("fetch_c1_mem_strobe", 64'(bus.mem_strobe), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      chk("fetch_wait_mem_valid", 64'(bus.mem_valid), 64'd1);
      chk("fetch_wait_no_ok", 64'(bus.iresp_ok), 64'd0);
    end
    cyc();
    complete(1'b0, 32'h1234_5678, 32'h100);
    chk("fetch_ok_i_wait", 64'(bus.i_wait), 64'd0);
    cyc();
    bus.mem_ready  = 1'b0;
    bus.ireq_valid = 1'b0;
    smp();
    chk("fetch_after_ok", 64'(bus.iresp_ok), 64'd0);
    chk("fetch_after_i_wait", 64'(bus.i_wait), 64'd0);
    chk("fetch_after_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("fetch_after_resp_data", 64'(bus.resp_data), 64'd0);

    // Tie: store wins, fetch follows after one idle cycle
    cyc();
    bus.ireq_valid  = 1'b1;
    bus.ireq_addr   = 32'h140;
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 32'h200;
    bus.dreq_write  = 1'b1;
    bus.dreq_strobe = 4'hF;
    bus.dreq_wdata  = 32'hDEAD_BEEF;
    smp();
    chk("tie_c0_mem_valid", 64'(bus.mem_valid), 64'd0);
    cyc();
    smp();
    chk("tie_d_mem_write", 64'(bus.mem_write), 64'd1);
    chk("tie_d_mem_addr", 64'(bus.mem_addr), 64'h200);
    chk("tie_d_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("tie_d_mem_strobe", 64'(bus.mem_strobe), 64'hF);
    chk("tie_i_wait", 64'(bus.i_wait), 64'd1);
    cyc();
    complete(1'b1, 32'hAAAA_0001, 32'h200);
    chk("tie_d_wait_at_ok", 64'(bus.d_wait), 64'd0);
    cyc();
    bus.mem_ready  = 1'b0;
    bus.dreq_valid = 1'b0;
    bus.dreq_write = 1'b0;
    smp();
    chk("tie_idle_gap", 64'(bus.mem_valid), 64'd0);
    cyc();
    smp();
    chk("tie_i_mem_valid", 64'(bus.mem_valid), 64'd1);
    chk("tie_i_mem_addr", 64'(bus.mem_addr), 64'h140);
    chk("tie_i_mem_write", 64'(bus.mem_write), 64'd0);
    chk("tie_i_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    cyc();
    complete(1'b0, 32'h0BAD_F00D, 32'h140);
    cyc();
    bus.mem_ready  = 1'b0;
    bus.ireq_valid = 1'b0;
    smp();
    chk("tie_end_mem_valid", 64'(bus.mem_valid), 64'd0);

    // Starvation: fetch held, loads keep coming, memory always ready
    cyc();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 32'h300;
    bus.dreq_valid = 1'b1;
    bus.dreq_addr  = 32'h400;
    bus.dreq_write = 1'b0;
    bus.dreq_strobe = '0;
    bus.dreq_wdata  = '0;
    bus.mem_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("starve_idle_mem_valid", 64'(bus.mem_valid), 64'd0);
      chk("starve_idle_no_ok", 64'(bus.iresp_ok | bus.dresp_ok), 64'd0);
      cyc();
      if (k < 4) begin
        complete(1'b1, 32'hD000_0000 | k, 32'h400 + 32'(4 * k));
        chk("starve_streak_d", 64'(dut.d_streak), 64'(k + 1));
      end else begin
        complete(1'b0, 32'h1000_0300, 32'h300);
        chk("starve_streak_i", 64'(dut.d_streak), 64'd0);
      end
      cyc();
      if (k < 4) begin
        bus.dreq_addr = 32'h400 + 32'(4 * (k + 1));
      end else begin
        bus.ireq_valid = 1'b0;
        bus.dreq_valid = 1'b0;
        bus.mem_ready  = 1'b0;
      end
    end
    smp();
    chk("starve_end_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("starve_end_streak", 64'(dut.d_streak), 64'd0);

    // Mid-flight drop: the store finishes with its original fields
    cyc();
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 32'h500;
    bus.dreq_write  = 1'b1;
    bus.dreq_strobe = 4'h3;
    bus.dreq_wdata  = 32'hCAFE_0001;
    cyc();
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = 32'h999;
    bus.dreq_write  = 1'b0;
    bus.dreq_strobe = 4'h0;
    bus.dreq_wdata  = 32'h0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("drop_mem_valid", 64'(bus.mem_valid), 64'd1);
      chk("drop_mem_addr", 64'(bus.mem_addr), 64'h500);
      chk("drop_mem_write", 64'(bus.mem_write), 64'd1);
      chk("drop_mem_strobe", 64'(bus.mem_strobe), 64'h3);
      chk("drop_mem_wdata", 64'(bus.mem_wdata), 64'hCAFE_0001);
      chk("drop_d_wait", 64'(bus.d_wait), 64'd0);
      cyc();
    end
    complete(1'b1, 32'h0000_5555, 32'h500);
    cyc();
    bus.mem_ready = 1'b0;
    smp();
    chk("drop_end_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("drop_end_state", 64'(dut.state), 64'(IDLE));

    // Async reset during a fetch, between clock edges
    cyc();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 32'h600;
    cyc();
    smp();
    chk("arst_pre_mem_valid", 64'(bus.mem_valid), 64'd1);
    #2;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_0600;
    #1;
    chk("arst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("arst_state", 64'(dut.state), 64'(IDLE));
    chk("arst_no_ok", 64'(bus.iresp_ok), 64'd0);
    chk("arst_mem_addr", 64'(bus.mem_addr), 64'd0);
    cyc();
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    smp();
    chk("arst_rel_mem_valid", 64'(bus.mem_valid), 64'd0);
    cyc();
    smp();
    chk("arst_regrant_valid", 64'(bus.mem_valid), 64'd1);
    chk("arst_regrant_addr", 64'(bus.mem_addr), 64'h600);
    cyc();
    complete(1'b0, 32'h0000_6666, 32'h600);
    cyc();
    bus.mem_ready  = 1'b0;
    bus.ireq_valid = 1'b0;

    // Spurious mem_ready while idle
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    smp();
    chk("spur_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("spur_no_ok", 64'({bus.iresp_ok, bus.dresp_ok}), 64'd0);
    chk("spur_resp_data", 64'(bus.resp_data), 64'd0);
    cyc();
    bus.mem_ready = 1'b0;
    smp();
    chk("spur_after_mem_valid", 64'(bus.mem_valid), 64'd0);

    cyc();
    smp();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
